// File: rtl/alien_wave_ctrl_pkg.sv
// Shared definitions for the alien-row wave controller: FSM state codes,
// alien count and default row geometry.
package alien_wave_ctrl_pkg;

    localparam int unsigned NUM_ALIENS = 5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_WON   = 3'd3;
    localparam logic [2:0] S_LOST  = 3'd4;

    localparam int unsigned DEF_ALIEN_X0    = 10;
    localparam int unsigned DEF_ALIEN_PITCH = 32;
    localparam int unsigned DEF_ALIEN_W     = 12;
    localparam int unsigned DEF_ALIEN_H     = 10;
    localparam int unsigned DEF_Y_START     = 10;
    localparam int unsigned DEF_STEP        = 5;
    localparam int unsigned DEF_MOVE_TICKS  = 60;
    localparam int unsigned DEF_LOSE_Y      = 100;

endpackage

// File: rtl/alien_hit_detect.sv
// Combinational bullet-vs-row hit test; returns a one-hot mask of the live
// alien whose box contains the bullet (PITCH > W keeps boxes disjoint).
import alien_wave_ctrl_pkg::*;

module alien_hit_detect #(
    parameter int unsigned ALIEN_X0    = DEF_ALIEN_X0,
    parameter int unsigned ALIEN_PITCH = DEF_ALIEN_PITCH,
    parameter int unsigned ALIEN_W     = DEF_ALIEN_W,
    parameter int unsigned ALIEN_H     = DEF_ALIEN_H
) (
    input  logic [7:0]            bulletX,
    input  logic [6:0]            bulletY,
    input  logic [6:0]            rowY,
    input  logic [NUM_ALIENS-1:0] alive,
    output logic [NUM_ALIENS-1:0] hit
);

    logic [8:0] bx, by, y_lo, y_hi, x_lo, x_hi;

    // All bounds are widened to 9 bits so the right/bottom edges never wrap.
    always_comb begin
        hit  = '0;
        bx   = {1'b0, bulletX};
        by   = {2'b00, bulletY};
        y_lo = {2'b00, rowY};
        y_hi = y_lo + 9'(ALIEN_H - 1);
        x_lo = '0;
        x_hi = '0;
        for (int unsigned i = 0; i < NUM_ALIENS; i++) begin
            x_lo   = 9'(ALIEN_X0 + i * ALIEN_PITCH);
            x_hi   = x_lo + 9'(ALIEN_W - 1);
            hit[i] = alive[i] && (bx >= x_lo) && (bx <= x_hi)
                     && (by >= y_lo) && (by <= y_hi);
        end
    end

endmodule

// File: rtl/alien_wave_ctrl.sv
// Game-state controller for one row of aliens: hit detection, clear and
// move-down handshakes with the draw datapath, move pacing and win/loss.
import alien_wave_ctrl_pkg::*;

module alien_wave_ctrl #(
    parameter int unsigned ALIEN_X0    = DEF_ALIEN_X0,
    parameter int unsigned ALIEN_PITCH = DEF_ALIEN_PITCH,
    parameter int unsigned ALIEN_W     = DEF_ALIEN_W,
    parameter int unsigned ALIEN_H     = DEF_ALIEN_H,
    parameter int unsigned Y_START     = DEF_Y_START,
    parameter int unsigned STEP        = DEF_STEP,
    parameter int unsigned MOVE_TICKS  = DEF_MOVE_TICKS,
    parameter int unsigned LOSE_Y      = DEF_LOSE_Y
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  bulletValid,
    input  logic [7:0]            bulletX,
    input  logic [6:0]            bulletY,
    input  logic [NUM_ALIENS-1:0] cleared,
    input  logic                  movedDown,
    output logic [NUM_ALIENS-1:0] clear,
    output logic                  moveDown,
    output logic                  hitAck,
    output logic [NUM_ALIENS-1:0] alienAlive,
    output logic [6:0]            rowY,
    output logic                  busy,
    output logic                  gameWon,
    output logic                  gameOver
);

    logic [2:0]            state;
    logic [NUM_ALIENS-1:0] hit, cleared_prev, alive_after;
    logic                  moved_prev, move_pend;
    logic [7:0]            tick_cnt, step_sum;
    logic [8:0]            step_bottom;
    logic                  terminal, expire, take_hit, take_move, clear_done, move_done;

    alien_hit_detect #(
        .ALIEN_X0    (ALIEN_X0),
        .ALIEN_PITCH (ALIEN_PITCH),
        .ALIEN_W     (ALIEN_W),
        .ALIEN_H     (ALIEN_H)
    ) u_hit (
        .bulletX (bulletX),
        .bulletY (bulletY),
        .rowY    (rowY),
        .alive   (alienAlive),
        .hit     (hit)
    );

    always_comb begin
        terminal    = (state == S_WON) || (state == S_LOST);
        expire      = !terminal && tick && (tick_cnt == 8'(MOVE_TICKS - 1));
        take_hit    = (state == S_IDLE) && bulletValid && (|hit);
        take_move   = (state == S_IDLE) && !take_hit && move_pend;
        // Only a fresh 0->1 edge on the requested alien's done bit completes a clear.
        clear_done  = (state == S_CLEAR) && (|(cleared & ~cleared_prev & clear));
        move_done   = (state == S_MOVE) && movedDown && !moved_prev;
        alive_after = alienAlive & ~clear;
        step_sum    = {1'b0, rowY} + 8'(STEP);
        step_bottom = {1'b0, step_sum} + 9'(ALIEN_H - 1);
    end

    assign busy     = (state == S_CLEAR) || (state == S_MOVE);
    assign gameWon  = (state == S_WON);
    assign gameOver = (state == S_LOST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            alienAlive   <= '1;
            rowY         <= 7'(Y_START);
            tick_cnt     <= '0;
            move_pend    <= 1'b0;
            clear        <= '0;
            moveDown     <= 1'b0;
            hitAck       <= 1'b0;
            cleared_prev <= '0;
            moved_prev   <= 1'b0;
        end else begin
            cleared_prev <= cleared;
            moved_prev   <= movedDown;
            hitAck       <= take_hit;

            if (!terminal && tick)
                tick_cnt <= expire ? '0 : tick_cnt + 8'd1;
            // A second expiry while a move is already pending is simply absorbed.
            if (expire)
                move_pend <= 1'b1;
            else if (take_move)
                move_pend <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (take_hit) begin
                        state <= S_CLEAR;
                        clear <= hit;
                    end else if (move_pend) begin
                        state    <= S_MOVE;
                        moveDown <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clear_done) begin
                        alienAlive <= alive_after;
                        clear      <= '0;
                        state      <= (alive_after == '0) ? S_WON : S_IDLE;
                    end
                end
                S_MOVE: begin
                    if (move_done) begin
                        moveDown <= 1'b0;
                        if (step_sum > 8'd127 || step_bottom >= 9'(LOSE_Y)) begin
                            state <= S_LOST;
                            rowY  <= (step_sum > 8'd127) ? 7'd127 : step_sum[6:0];
                        end else begin
                            state <= S_IDLE;
                            rowY  <= step_sum[6:0];
                        end
                    end
                end
                default: begin
                    clear    <= '0;
                    moveDown <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alien_wave_ctrl.sv
// Directed bench for alien_wave_ctrl: geometry vector table plus hand-written
// handshake, pacing, win, loss and async-reset sequences.
module tb_alien_wave_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       bulletValid;
    logic [7:0] bulletX;
    logic [6:0] bulletY;
    logic [4:0] cleared;
    logic       movedDown;
    logic [4:0] clear;
    logic       moveDown;
    logic       hitAck;
    logic [4:0] alienAlive;
    logic [6:0] rowY;
    logic       busy;
    logic       gameWon;
    logic       gameOver;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alien_wave_ctrl #(
        .MOVE_TICKS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .bulletValid (bulletValid),
        .bulletX     (bulletX),
        .bulletY     (bulletY),
        .cleared     (cleared),
        .movedDown   (movedDown),
        .clear       (clear),
        .moveDown    (moveDown),
        .hitAck      (hitAck),
        .alienAlive  (alienAlive),
        .rowY        (rowY),
        .busy        (busy),
        .gameWon     (gameWon),
        .gameOver    (gameOver)
    );

    typedef struct {
        logic       valid;
        logic [7:0] x;
        logic [6:0] y;
        logic [4:0] exp_clear;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        tick        = 1'b0;
        bulletValid = 1'b0;
        bulletX     = '0;
        bulletY     = '0;
        cleared     = '0;
        movedDown   = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic shoot(input logic [7:0] x, input logic [6:0] y);
        bulletValid = 1'b1;
        bulletX     = x;
        bulletY     = y;
        step();
        bulletValid = 1'b0;
    endtask

    task automatic do_move(input logic [6:0] exp_row, input logic exp_over);
        repeat (4) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
        step();
        chk("move_req", moveDown, 1'b1);
        movedDown = 1'b1;
        step();
        movedDown = 1'b0;
        chk("move_row", rowY, exp_row);
        chk("move_over", gameOver, exp_over);
        step();
    endtask

    initial begin
        // rowY = 10 after reset, so live rows span y 10..19
        vecs[0]  = '{1'b1, 8'd15,  7'd12, 5'b00001};
        vecs[1]  = '{1'b1, 8'd10,  7'd10, 5'b00001};
        vecs[2]  = '{1'b1, 8'd21,  7'd19, 5'b00001};
        vecs[3]  = '{1'b1, 8'd22,  7'd12, 5'b00000};
        vecs[4]  = '{1'b1, 8'd9,   7'd12, 5'b00000};
        vecs[5]  = '{1'b1, 8'd30,  7'd12, 5'b00000};
        vecs[6]  = '{1'b1, 8'd42,  7'd15, 5'b00010};
        vecs[7]  = '{1'b1, 8'd53,  7'd15, 5'b00010};
        vecs[8]  = '{1'b1, 8'd74,  7'd15, 5'b00100};
        vecs[9]  = '{1'b1, 8'd106, 7'd11, 5'b01000};
        vecs[10] = '{1'b1, 8'd149, 7'd18, 5'b10000};
        vecs[11] = '{1'b1, 8'd150, 7'd18, 5'b00000};
        vecs[12] = '{1'b1, 8'd15,  7'd9,  5'b00000};
        vecs[13] = '{1'b1, 8'd15,  7'd20, 5'b00000};
        vecs[14] = '{1'b0, 8'd15,  7'd12, 5'b00000};

        do_reset();
        chk("rst_alive", alienAlive, 5'b11111);
        chk("rst_row", rowY, 7'd10);
        chk("rst_clear", clear, 5'b0);
        chk("rst_move", moveDown, 1'b0);
        chk("rst_won", gameWon, 1'b0);
        chk("rst_over", gameOver, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", hitAck, 1'b0);

        for (int i = 0; i < 15; i++) begin
            do_reset();
            bulletValid = vecs[i].valid;
            bulletX     = vecs[i].x;
            bulletY     = vecs[i].y;
            step();
            bulletValid = 1'b0;
            chk($sformatf("vec%0d_clear", i), clear, vecs[i].exp_clear);
            chk($sformatf("vec%0d_ack", i), hitAck, |vecs[i].exp_clear);
        end

        // Clear handshake, gap, dead alien, sticky done, bullet ignored while busy
        do_reset();
        shoot(8'd15, 7'd12);
        chk("b_clear", clear, 5'b00001);
        chk("b_ack", hitAck, 1'b1);
        step();
        chk("b_ack_pulse", hitAck, 1'b0);
        chk("b_clear_held", clear, 5'b00001);
        chk("b_busy", busy, 1'b1);
        cleared = 5'b00001;
        step();
        chk("b_done_clear", clear, 5'b0);
        chk("b_done_alive", alienAlive, 5'b11110);
        chk("b_done_busy", busy, 1'b0);
        shoot(8'd30, 7'd12);
        chk("b_gap_clear", clear, 5'b0);
        chk("b_gap_ack", hitAck, 1'b0);
        shoot(8'd15, 7'd12);
        chk("b_dead_clear", clear, 5'b0);
        chk("b_dead_ack", hitAck, 1'b0);
        shoot(8'd42, 7'd15);
        chk("b_a1_clear", clear, 5'b00010);
        shoot(8'd74, 7'd15);
        chk("b_busy_ack", hitAck, 1'b0);
        chk("b_busy_clear", clear, 5'b00010);
        step();
        chk("b_sticky", clear, 5'b00010);
        cleared = 5'b00011;
        step();
        chk("b_a1_alive", alienAlive, 5'b11100);
        step();
        chk("b_noqueue_clear", clear, 5'b0);
        chk("b_noqueue_ack", hitAck, 1'b0);

        // Move pacing with MOVE_TICKS=4
        do_move(7'd15, 1'b0);

        // Hit and tick expiry on the same cycle: clear first, then move
        repeat (3) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
        tick = 1'b1;
        shoot(8'd74, 7'd16);
        tick = 1'b0;
        chk("d_clear", clear, 5'b00100);
        chk("d_nomove", moveDown, 1'b0);
        cleared = 5'b00111;
        step();
        chk("d_clear_done", clear, 5'b0);
        chk("d_alive", alienAlive, 5'b11000);
        step();
        chk("d_move", moveDown, 1'b1);
        movedDown = 1'b1;
        step();
        movedDown = 1'b0;
        chk("d_row", rowY, 7'd20);
        step();

        // Kill remaining aliens -> win, then everything is ignored
        shoot(8'd106, 7'd21);
        chk("e_a3_clear", clear, 5'b01000);
        cleared = 5'b01111;
        step();
        chk("e_a3_alive", alienAlive, 5'b10000);
        chk("e_a3_won", gameWon, 1'b0);
        shoot(8'd138, 7'd21);
        chk("e_a4_clear", clear, 5'b10000);
        cleared = 5'b11111;
        step();
        chk("e_won", gameWon, 1'b1);
        chk("e_alive", alienAlive, 5'b0);
        chk("e_busy", busy, 1'b0);
        chk("e_over", gameOver, 1'b0);
        cleared = 5'b0;
        for (int i = 0; i < 8; i++) begin
            tick        = 1'b1;
            bulletValid = 1'b1;
            bulletX     = 8'd138;
            bulletY     = 7'd21;
            step();
            chk($sformatf("e_idle%0d", i), {hitAck, moveDown, clear}, 7'b0);
        end
        tick        = 1'b0;
        bulletValid = 1'b0;
        chk("e_won_held", gameWon, 1'b1);

        // Descend until the row bottom crosses the loss line
        do_reset();
        for (int k = 1; k <= 17; k++)
            do_move(7'(10 + 5 * k), (k == 17));
        chk("f_over", gameOver, 1'b1);
        chk("f_row", rowY, 7'd95);
        chk("f_move_low", moveDown, 1'b0);
        chk("f_busy", busy, 1'b0);

        // Asynchronous reset in the middle of a clear request
        do_reset();
        shoot(8'd15, 7'd12);
        chk("g_clear", clear, 5'b00001);
        #2;
        reset = 1'b0;
        #1;
        chk("g_async_clear", clear, 5'b0);
        chk("g_async_alive", alienAlive, 5'b11111);
        step();
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
